// File: rtl/cache_mem_arbiter.sv
// Two-port round-robin arbiter sharing one in-order memory port between the
// instruction cache (port 0) and the data cache (port 1).
module cache_mem_arbiter #(
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                               clk,
   input  logic                               reset,

   input  logic                               in0_req_val,
   output logic                               in0_req_rdy,
   input  logic [76:0]                        in0_req_msg,
   output logic                               in0_resp_val,
   input  logic                               in0_resp_rdy,
   output logic [46:0]                        in0_resp_msg,

   input  logic                               in1_req_val,
   output logic                               in1_req_rdy,
   input  logic [76:0]                        in1_req_msg,
   output logic                               in1_resp_val,
   input  logic                               in1_resp_rdy,
   output logic [46:0]                        in1_resp_msg,

   output logic                               memreq_val,
   input  logic                               memreq_rdy,
   output logic [76:0]                        memreq_msg,
   input  logic                               memresp_val,
   output logic                               memresp_rdy,
   input  logic [46:0]                        memresp_msg,

   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);

   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {StFree, StLocked} lock_state_e;

   lock_state_e                state_q, state_d;
   logic                       lock_port_q, lock_port_d;
   logic                       prio_q, prio_d;
   logic [CNT_W-1:0]           count_q, count_d;
   logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
   logic [MAX_OUTSTANDING-1:0] id_fifo_q;

   logic grant, full, empty, go, head, req_fire, resp_fire;

   always_comb begin
      state_d     = state_q;
      lock_port_d = lock_port_q;
      prio_d      = prio_q;
      count_d     = count_q;

      grant = prio_q;
      if (state_q == StLocked) begin
         grant = lock_port_q;
      end else if (in0_req_val && !in1_req_val) begin
         grant = 1'b0;
      end else if (in1_req_val && !in0_req_val) begin
         grant = 1'b1;
      end

      full  = (count_q == CNT_W'(MAX_OUTSTANDING));
      empty = (count_q == '0);
      // reset gates the request side combinationally so nothing leaks while held
      go    = reset && !full;

      memreq_val  = (grant ? in1_req_val : in0_req_val) && go;
      memreq_msg  = grant ? in1_req_msg : in0_req_msg;
      in0_req_rdy = !grant && memreq_rdy && go;
      in1_req_rdy = grant && memreq_rdy && go;
      req_fire    = memreq_val && memreq_rdy;

      head         = id_fifo_q[rd_ptr_q];
      memresp_rdy  = (head ? in1_resp_rdy : in0_resp_rdy) && !empty;
      in0_resp_val = memresp_val && !empty && !head;
      in1_resp_val = memresp_val && !empty && head;
      in0_resp_msg = memresp_msg;
      in1_resp_msg = memresp_msg;
      resp_fire    = memresp_val && memresp_rdy;

      // a stalled request pins the grant so memreq_msg cannot change under it
      if (memreq_val && !memreq_rdy) begin
         state_d     = StLocked;
         lock_port_d = grant;
      end else begin
         state_d = StFree;
      end

      if (req_fire) begin
         prio_d = ~grant;
      end

      case ({req_fire, resp_fire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StFree;
         lock_port_q <= 1'b0;
         prio_q      <= 1'b0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         id_fifo_q   <= '0;
      end else begin
         state_q     <= state_d;
         lock_port_q <= lock_port_d;
         prio_q      <= prio_d;
         count_q     <= count_d;
         if (req_fire) begin
            id_fifo_q[wr_ptr_q] <= grant;
            wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
         end
         if (resp_fire) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   assign outstanding = count_q;

endmodule
